ctrl_decode_unit: RTL and testbench



---
 rtl/ctrl_pkg.sv | 42 ++++
 rtl/ctrl_decode_unit_if.sv | 23 ++
 rtl/ctrl_decode_comb.sv | 48 ++++
 rtl/ctrl_decode_unit.sv | 33 +++
 tb/tb_ctrl_decode_unit.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings and the control bundle for the IF/ID instruction decoder.
package ctrl_pkg;

    localparam logic [3:0] OP_RTYPE = 4'd0;
    localparam logic [3:0] OP_ANDI  = 4'd2;
    localparam logic [3:0] OP_ORI   = 4'd3;
    localparam logic [3:0] OP_BLT   = 4'd4;
    localparam logic [3:0] OP_BGT   = 4'd5;
    localparam logic [3:0] OP_BEQ   = 4'd6;
    localparam logic [3:0] OP_LBU   = 4'd8;
    localparam logic [3:0] OP_LW    = 4'd9;
    localparam logic [3:0] OP_SB    = 4'd10;
    localparam logic [3:0] OP_SW    = 4'd11;
    localparam logic [3:0] OP_JMP   = 4'd12;
    localparam logic [3:0] OP_HALT  = 4'd15;

    localparam logic [3:0] FN_ADD = 4'd1;
    localparam logic [3:0] FN_SUB = 4'd2;
    localparam logic [3:0] FN_AND = 4'd3;
    localparam logic [3:0] FN_OR  = 4'd4;
    localparam logic [3:0] FN_MUL = 4'd5;
    localparam logic [3:0] FN_DIV = 4'd6;
    localparam logic [3:0] FN_SLL = 4'd8;
    localparam logic [3:0] FN_SRL = 4'd9;
    localparam logic [3:0] FN_ROL = 4'd10;
    localparam logic [3:0] FN_ROR = 4'd11;
    localparam logic [3:0] FN_MOV = 4'd12;
    localparam logic [3:0] FN_SWP = 4'd13;

    localparam logic [1:0] RW_NONE   = 2'b00;
    localparam logic [1:0] RW_OP1    = 2'b01;
    localparam logic [1:0] RW_OP1_R0 = 2'b10;
    localparam logic [1:0] RW_BOTH   = 2'b11;

    typedef struct packed {
        logic       immd;
        logic       mem_wr;
        logic       mem_rd;
        logic [1:0] reg_wr;
    } ctrl_t;

endpackage

// File: rtl/ctrl_decode_unit_if.sv
// Pipeline-control inputs, instruction fields and registered control outputs of the decoder.
interface ctrl_decode_unit_if;

    logic       stall;
    logic       flush;
    logic [3:0] OpCode;
    logic [3:0] FuncCode;
    logic       IFIDImmd;
    logic       IFIDMemWrite;
    logic       IFIDMemRead;
    logic [1:0] IFIDRegWrite;

    modport master (
        output stall, flush, OpCode, FuncCode,
        input  IFIDImmd, IFIDMemWrite, IFIDMemRead, IFIDRegWrite
    );

    modport slave (
        input  stall, flush, OpCode, FuncCode,
        output IFIDImmd, IFIDMemWrite, IFIDMemRead, IFIDRegWrite
    );

endinterface

// File: rtl/ctrl_decode_comb.sv
// Purely combinational opcode/function-code to control-bundle decode table.
module ctrl_decode_comb
    import ctrl_pkg::*;
(
    input  logic [3:0] op_code,
    input  logic [3:0] func_code,
    output ctrl_t      ctrl
);

    // Undefined opcodes and function codes fall through to the all-zero NOP.
    always_comb begin
        ctrl = '0;
        case (op_code)
            OP_RTYPE: begin
                case (func_code)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_MOV:
                        ctrl.reg_wr = RW_OP1;
                    FN_MUL, FN_DIV:
                        ctrl.reg_wr = RW_OP1_R0;
                    FN_SLL, FN_SRL, FN_ROL, FN_ROR: begin
                        ctrl.immd   = 1'b1;
                        ctrl.reg_wr = RW_OP1;
                    end
                    FN_SWP:
                        ctrl.reg_wr = RW_BOTH;
                    default: ctrl = '0;
                endcase
            end
            OP_ANDI, OP_ORI: begin
                ctrl.immd   = 1'b1;
                ctrl.reg_wr = RW_OP1;
            end
            OP_BLT, OP_BGT, OP_BEQ, OP_JMP:
                ctrl.immd = 1'b1;
            OP_LBU, OP_LW: begin
                ctrl.immd   = 1'b1;
                ctrl.mem_rd = 1'b1;
                ctrl.reg_wr = RW_OP1;
            end
            OP_SB, OP_SW: begin
                ctrl.immd   = 1'b1;
                ctrl.mem_wr = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/ctrl_decode_unit.sv
// IF/ID control decoder: decodes the fetched instruction and registers the controls into ID.
module ctrl_decode_unit
    import ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    ctrl_decode_unit_if.slave    bus
);

    ctrl_t decoded;
    ctrl_t ctrl_q;

    ctrl_decode_comb u_decode (
        .op_code   (bus.OpCode),
        .func_code (bus.FuncCode),
        .ctrl      (decoded)
    );

    // Flush inserts a bubble even while stalled, so it is checked before stall.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            ctrl_q <= '0;
        end else if (!bus.stall) begin
            ctrl_q <= decoded;
        end
    end

    assign bus.IFIDImmd     = ctrl_q.immd;
    assign bus.IFIDMemWrite = ctrl_q.mem_wr;
    assign bus.IFIDMemRead  = ctrl_q.mem_rd;
    assign bus.IFIDRegWrite = ctrl_q.reg_wr;

endmodule

// File: tb/tb_ctrl_decode_unit.sv
// Directed and randomized checks of the registered instruction decoder.
module tb_ctrl_decode_unit;

    logic clk;
    logic rst;
    int   passed;
    int   total;

    logic [4:0] op_tab [16];
    logic [4:0] fn_tab [16];

    ctrl_decode_unit_if bus ();

    ctrl_decode_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed outputs packed as {Immd, MemWrite, MemRead, RegWrite}.
    function automatic logic [4:0] observed();
        return {bus.IFIDImmd, bus.IFIDMemWrite, bus.IFIDMemRead, bus.IFIDRegWrite};
    endfunction

    function automatic logic [4:0] ref_decode(input logic [3:0] op, input logic [3:0] fn);
        if (op == 4'd0) return fn_tab[fn];
        return op_tab[op];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [4:0] obs;
        rst = 1'b1; bus.stall = 1'bx; bus.flush = 1'bx;
        bus.OpCode = 4'bxxxx; bus.FuncCode = 4'bzzzz;
        step();
        obs = observed();
        total++;
        if (obs !== 5'b0_0_0_00) $display("[TB] FAIL reset_x got %b want %b", obs, 5'b0);
        else passed++;
        bus.stall = 1'b0; bus.flush = 1'b0; bus.OpCode = 4'd8; bus.FuncCode = 4'd0;
        step(); step();
        obs = observed();
        total++;
        if (obs !== 5'b0_0_0_00) $display("[TB] FAIL reset_hold got %b want %b", obs, 5'b0);
        else passed++;
        rst = 1'b0;
        step();
        obs = observed();
        total++;
        if (obs !== 5'b1_0_1_01) $display("[TB] FAIL reset_release got %b want %b", obs, 5'b1_0_1_01);
        else passed++;
    endtask

    task automatic test_rtype();
        logic [3:0] fns  [11] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11, 4'd13, 4'd0};
        logic [4:0] exps [11] = '{5'b0_0_0_01, 5'b0_0_0_01, 5'b0_0_0_01, 5'b0_0_0_01, 5'b0_0_0_10,
                                  5'b1_0_0_01, 5'b1_0_0_01, 5'b1_0_0_01, 5'b1_0_0_01,
                                  5'b0_0_0_11, 5'b0_0_0_00};
        logic [4:0] obs;
        bus.OpCode = 4'd0;
        for (int i = 0; i < 11; i++) begin
            bus.FuncCode = fns[i];
            step();
            obs = observed();
            total++;
            if (obs !== exps[i]) $display("[TB] FAIL rtype_fn%0d got %b want %b", fns[i], obs, exps[i]);
            else passed++;
        end
    endtask

    task automatic test_opcodes();
        logic [3:0] ops  [9] = '{4'd8, 4'd11, 4'd4, 4'd5, 4'd6, 4'd12, 4'd15, 4'd2, 4'd3};
        logic [4:0] exps [9] = '{5'b1_0_1_01, 5'b1_1_0_00, 5'b1_0_0_00, 5'b1_0_0_00, 5'b1_0_0_00,
                                 5'b1_0_0_00, 5'b0_0_0_00, 5'b1_0_0_01, 5'b1_0_0_01};
        logic [4:0] obs;
        for (int i = 0; i < 9; i++) begin
            bus.OpCode   = ops[i];
            bus.FuncCode = 4'(i * 3 + 1);
            step();
            obs = observed();
            total++;
            if (obs !== exps[i]) $display("[TB] FAIL opcode_%0d got %b want %b", ops[i], obs, exps[i]);
            else passed++;
        end
    endtask

    task automatic test_stall_flush();
        logic [4:0] obs;
        bus.OpCode = 4'd11; bus.FuncCode = 4'd0;
        step();
        obs = observed();
        total++;
        if (obs !== 5'b1_1_0_00) $display("[TB] FAIL stall_load got %b want %b", obs, 5'b1_1_0_00);
        else passed++;
        bus.stall = 1'b1; bus.OpCode = 4'd8;
        step(); step();
        obs = observed();
        total++;
        if (obs !== 5'b1_1_0_00) $display("[TB] FAIL stall_hold got %b want %b", obs, 5'b1_1_0_00);
        else passed++;
        bus.flush = 1'b1;
        step();
        obs = observed();
        total++;
        if (obs !== 5'b0_0_0_00) $display("[TB] FAIL flush_over_stall got %b want %b", obs, 5'b0);
        else passed++;
        bus.flush = 1'b0; bus.stall = 1'b0;
        step();
        obs = observed();
        total++;
        if (obs !== 5'b1_0_1_01) $display("[TB] FAIL after_flush got %b want %b", obs, 5'b1_0_1_01);
        else passed++;
        bus.OpCode = 4'd9; bus.flush = 1'b1;
        step();
        obs = observed();
        total++;
        if (obs !== 5'b0_0_0_00) $display("[TB] FAIL flush_only got %b want %b", obs, 5'b0);
        else passed++;
        bus.flush = 1'b0;
    endtask

    task automatic test_random();
        logic [3:0] op;
        logic [3:0] fn;
        logic [4:0] exp;
        logic [4:0] obs;
        for (int i = 0; i < 1000; i++) begin
            op = 4'($urandom_range(0, 15));
            fn = 4'($urandom_range(0, 15));
            bus.OpCode = op; bus.FuncCode = fn;
            exp = ref_decode(op, fn);
            step();
            obs = observed();
            total++;
            if (obs !== exp) $display("[TB] FAIL random op=%0d fn=%0d got %b want %b", op, fn, obs, exp);
            else passed++;
            total++;
            if ((obs[3] && obs[2]) || (obs[3] && obs[1:0] != 2'b00))
                $display("[TB] FAIL invariant op=%0d fn=%0d got %b want no rd+wr, wr=>rw00", op, fn, obs);
            else passed++;
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;
        for (int i = 0; i < 16; i++) begin
            op_tab[i] = 5'b0;
            fn_tab[i] = 5'b0;
        end
        fn_tab[1]  = 5'b0_0_0_01; fn_tab[2]  = 5'b0_0_0_01; fn_tab[3]  = 5'b0_0_0_01;
        fn_tab[4]  = 5'b0_0_0_01; fn_tab[5]  = 5'b0_0_0_10; fn_tab[6]  = 5'b0_0_0_10;
        fn_tab[8]  = 5'b1_0_0_01; fn_tab[9]  = 5'b1_0_0_01; fn_tab[10] = 5'b1_0_0_01;
        fn_tab[11] = 5'b1_0_0_01; fn_tab[12] = 5'b0_0_0_01; fn_tab[13] = 5'b0_0_0_11;
        op_tab[2]  = 5'b1_0_0_01; op_tab[3]  = 5'b1_0_0_01;
        op_tab[4]  = 5'b1_0_0_00; op_tab[5]  = 5'b1_0_0_00; op_tab[6]  = 5'b1_0_0_00;
        op_tab[8]  = 5'b1_0_1_01; op_tab[9]  = 5'b1_0_1_01;
        op_tab[10] = 5'b1_1_0_00; op_tab[11] = 5'b1_1_0_00;
        op_tab[12] = 5'b1_0_0_00;

        test_reset();
        test_rtype();
        test_opcodes();
        test_stall_flush();
        test_random();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
